// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared flit encodings, field positions, status codes and NI state type
package noc_pkg;

  typedef enum logic [1:0] {
    KIND_HEAD   = 2'b00,
    KIND_BODY   = 2'b01,
    KIND_TAIL   = 2'b10,
    KIND_SINGLE = 2'b11
  } kind_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_DROP,
    ST_DELIVER,
    ST_ACK
  } state_e;

  // Low bit of each flit field; row/col pairs are handled as one 8-bit field.
  localparam int KIND_LSB = 62;
  localparam int DST_LSB  = 54;
  localparam int SRC_LSB  = 46;
  localparam int LEN_LSB  = 43;
  localparam int STAT_LSB = 24;
  localparam int CNT_LSB  = 16;

  localparam logic [7:0] STAT_OK      = 8'h00;
  localparam logic [7:0] STAT_BAD_DST = 8'h01;
  localparam logic [7:0] STAT_BAD_LEN = 8'h02;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/noc_eject_ni_if.sv
// rtl/noc_eject_ni_if.sv - router-side flit ports and tile-side packet port of the ejection NI
interface noc_eject_ni_if #(
  parameter int FLIT_W  = 64,
  parameter int MAX_LEN = 4
);
  logic [FLIT_W-1:0]         rx_flit;
  logic                      rx_valid;
  logic                      rx_ready;
  logic [FLIT_W-1:0]         tx_flit;
  logic                      tx_valid;
  logic                      tx_ready;
  logic [(MAX_LEN+1)*32-1:0] pkt_data;
  logic [2:0]                pkt_words;
  logic [7:0]                pkt_src;
  logic                      pkt_valid;
  logic                      pkt_ready;
  logic [15:0]               pkt_cnt;
  logic [15:0]               err_cnt;

  modport master (
    output rx_flit, rx_valid, tx_ready, pkt_ready,
    input  rx_ready, tx_flit, tx_valid, pkt_data, pkt_words, pkt_src, pkt_valid, pkt_cnt, err_cnt
  );

  modport slave (
    input  rx_flit, rx_valid, tx_ready, pkt_ready,
    output rx_ready, tx_flit, tx_valid, pkt_data, pkt_words, pkt_src, pkt_valid, pkt_cnt, err_cnt
  );
endinterface

// File: rtl/noc_ack_builder.sv
// rtl/noc_ack_builder.sv - formats the SINGLE ack flit returned to the packet source
module noc_ack_builder
  import noc_pkg::*;
#(
  parameter int         FLIT_W = 64,
  parameter logic [3:0] MY_ROW = 4'd0,
  parameter logic [3:0] MY_COL = 4'd0
) (
  input  logic [7:0]        i_dst,
  input  logic [7:0]        i_status,
  input  logic [2:0]        i_words,
  output logic [FLIT_W-1:0] o_flit
);
  always_comb begin
    o_flit                   = '0;
    o_flit[KIND_LSB +: 2]    = KIND_SINGLE;
    o_flit[DST_LSB +: 8]     = i_dst;
    o_flit[SRC_LSB +: 8]     = {MY_ROW, MY_COL};
    o_flit[STAT_LSB +: 8]    = i_status;
    o_flit[CNT_LSB +: 8]     = {5'd0, i_words};
  end
endmodule

// File: rtl/noc_eject_ni.sv
// rtl/noc_eject_ni.sv - NoC ejection NI: reassembles packets, delivers them to the tile, returns an ack
module noc_eject_ni
  import noc_pkg::*;
#(
  parameter int         FLIT_W  = 64,
  parameter int         MAX_LEN = 4,
  parameter logic [3:0] MY_ROW  = 4'd0,
  parameter logic [3:0] MY_COL  = 4'd0
) (
  input logic           clk,
  input logic           rst,
  noc_eject_ni_if.slave nif
);
  state_e      r_state;
  logic [31:0] r_word [MAX_LEN+1];
  logic [2:0]  r_words;
  logic [2:0]  r_left;
  logic [7:0]  r_src;
  logic [7:0]  r_status;
  logic [15:0] r_pkt_cnt;
  logic [15:0] r_err_cnt;

  kind_e             w_kind;
  logic [2:0]        w_len;
  logic [31:0]       w_data;
  logic              w_dst_hit;
  logic              w_len_ok;
  logic              w_rx_fire;
  logic [FLIT_W-1:0] w_ack_flit;
  logic              w_unused;

  assign w_kind    = kind_e'(nif.rx_flit[KIND_LSB +: 2]);
  assign w_len     = nif.rx_flit[LEN_LSB +: 3];
  assign w_data    = nif.rx_flit[31:0];
  assign w_dst_hit = (nif.rx_flit[DST_LSB +: 8] == {MY_ROW, MY_COL});
  assign w_len_ok  = (w_len != 3'd0) && (int'(w_len) <= MAX_LEN);
  assign w_unused  = &{1'b0, nif.rx_flit[42:32]};

  // Gating with rst lets rx_ready fall during reset yet rise on the first cycle after it.
  assign nif.rx_ready = !rst && (r_state == ST_IDLE || r_state == ST_RECV || r_state == ST_DROP);
  assign w_rx_fire    = nif.rx_valid && nif.rx_ready;

  noc_ack_builder #(.FLIT_W(FLIT_W), .MY_ROW(MY_ROW), .MY_COL(MY_COL)) u_ack (
    .i_dst    (r_src),
    .i_status (r_status),
    .i_words  (r_words),
    .o_flit   (w_ack_flit)
  );

  assign nif.pkt_valid = (r_state == ST_DELIVER);
  assign nif.tx_valid  = (r_state == ST_ACK);
  assign nif.tx_flit   = nif.tx_valid ? w_ack_flit : '0;
  assign nif.pkt_words = r_words;
  assign nif.pkt_src   = r_src;
  assign nif.pkt_cnt   = r_pkt_cnt;
  assign nif.err_cnt   = r_err_cnt;

  for (genvar g = 0; g <= MAX_LEN; g++) begin : g_pack
    assign nif.pkt_data[32*g +: 32] = r_word[g];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_words   <= '0;
      r_left    <= '0;
      r_src     <= '0;
      r_status  <= '0;
      r_pkt_cnt <= '0;
      r_err_cnt <= '0;
      for (int i = 0; i <= MAX_LEN; i++) r_word[i] <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: if (w_rx_fire) begin
          unique case (w_kind)
            KIND_HEAD, KIND_SINGLE: begin
              r_src   <= nif.rx_flit[SRC_LSB +: 8];
              r_words <= 3'd0;
              for (int i = 0; i <= MAX_LEN; i++) r_word[i] <= '0;
              if (!w_dst_hit) begin
                r_status  <= STAT_BAD_DST;
                r_err_cnt <= sat_inc16(r_err_cnt);
                if (w_kind == KIND_SINGLE) r_state <= ST_ACK;
                else                       r_state <= ST_DROP;
              end else if (w_kind == KIND_SINGLE) begin
                r_word[0] <= w_data;
                r_words   <= 3'd1;
                r_status  <= STAT_OK;
                r_state   <= ST_DELIVER;
              end else if (!w_len_ok) begin
                r_status  <= STAT_BAD_LEN;
                r_err_cnt <= sat_inc16(r_err_cnt);
                r_state   <= ST_DROP;
              end else begin
                r_word[0] <= w_data;
                r_words   <= 3'd1;
                r_left    <= w_len;
                r_status  <= STAT_OK;
                r_state   <= ST_RECV;
              end
            end
            KIND_BODY, KIND_TAIL: r_err_cnt <= sat_inc16(r_err_cnt);
          endcase
        end
        ST_RECV: if (w_rx_fire) begin
          // A stray HEAD/SINGLE ends the packet but its word is not kept.
          if (w_kind == KIND_BODY || w_kind == KIND_TAIL) begin
            r_word[r_words] <= w_data;
            r_words         <= r_words + 3'd1;
            r_left          <= r_left - 3'd1;
          end
          if (w_kind == KIND_BODY && r_left > 3'd1) begin
            r_state <= ST_RECV;
          end else if (w_kind == KIND_TAIL && r_left == 3'd1) begin
            r_state <= ST_DELIVER;
          end else begin
            r_status  <= STAT_BAD_LEN;
            r_err_cnt <= sat_inc16(r_err_cnt);
            r_state   <= ST_ACK;
          end
        end
        ST_DROP: if (w_rx_fire && w_kind == KIND_TAIL) r_state <= ST_ACK;
        ST_DELIVER: if (nif.pkt_ready) begin
          r_pkt_cnt <= r_pkt_cnt + 16'd1;
          r_status  <= STAT_OK;
          r_state   <= ST_ACK;
        end
        ST_ACK: if (nif.tx_ready) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/noc_eject_ni.md
NOC_EJECT_NI -- requirements
Module: noc_eject_ni

Interface
REQ-001 SHALL have parameters: FLIT_W=64 (flit width); MAX_LEN=4 (max flits after head); MY_ROW=0 and MY_COL=0 (this tile's mesh coordinates, 4 bits each).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- rx_flit  in  FLIT_W  flit from router local output port.
- rx_valid  in  1  rx_flit valid.
- rx_ready  out  1  NI accepts rx_flit.
- tx_flit  out  FLIT_W  ack flit to router local input port.
- tx_valid  out  1  tx_flit valid.
- tx_ready  in  1  router accepts tx_flit.
- pkt_data  out  (MAX_LEN+1)*32  reassembled words; word 0 is the head word.
- pkt_words  out  3  number of valid words, 1..MAX_LEN+1.
- pkt_src  out  8  {src_row, src_col}.
- pkt_valid  out  1  packet available to tile.
- pkt_ready  in  1  tile consumes packet.
- pkt_cnt  out  16  good packets delivered; wraps.
- err_cnt  out  16  errored or dropped packets/flits; saturates at 16'hFFFF.
REQ-003 Flit format SHALL be:
- [63:62] kind: 00 HEAD, 01 BODY, 10 TAIL, 11 SINGLE.
- Head/single: [61:58] dst_row, [57:54] dst_col, [53:50] src_row, [49:46] src_col, [45:43] len.
- All kinds: [31:0] data word.

Function
REQ-004 The FSM SHALL have states IDLE, RECV, DROP, DELIVER, ACK.
REQ-005 A flit SHALL transfer only on a cycle with rx_valid && rx_ready; tx and pkt handshakes SHALL follow the same valid&&ready rule.
REQ-006 rx_ready SHALL be 1 in IDLE, RECV and DROP, and 0 in DELIVER and ACK.
REQ-007 In IDLE, SINGLE with matching dst SHALL store word 0 and go to DELIVER with pkt_words=1; pkt_valid SHALL be asserted the cycle after acceptance.
REQ-008 In IDLE, HEAD with matching dst and 1<=len<=MAX_LEN SHALL store word 0, load a remaining-count of len, and go to RECV.
REQ-009 In IDLE, HEAD with len=0 or len>MAX_LEN SHALL set status 8'h02, increment err_cnt, and go to DROP.
REQ-010 In IDLE, HEAD or SINGLE with dst mismatch SHALL set status 8'h01 and increment err_cnt; HEAD then goes to DROP, SINGLE goes directly to ACK.
REQ-011 In IDLE, BODY or TAIL SHALL be consumed and discarded with err_cnt incremented, no ack, and the FSM staying in IDLE.
REQ-012 In RECV, each accepted flit SHALL store its word at the next index and decrement the count:
- BODY with count>1 stays in RECV.
- TAIL with count==1 goes to DELIVER.
- Any other kind/count combination SHALL set status 8'h02, increment err_cnt and go to ACK; a HEAD or SINGLE arriving here is consumed and discarded.
REQ-013 DROP SHALL consume flits until a TAIL is accepted, then go to ACK.
REQ-014 DELIVER SHALL hold pkt_valid and all pkt_* outputs stable until pkt_ready; on that handshake it SHALL increment pkt_cnt, set status 8'h00, and go to ACK.
REQ-015 ACK SHALL drive tx_valid=1 with a SINGLE flit carrying:
- dst = stored src; src = {MY_ROW, MY_COL}; len=0.
- [31:24] status, [23:16] words received, all other bits 0.
tx_flit SHALL be held stable until tx_ready, then the FSM goes to IDLE.
REQ-016 pkt_valid and tx_valid SHALL never be asserted in the same cycle; pkt_valid SHALL be 0 outside DELIVER and tx_valid SHALL be 0 outside ACK.
REQ-017 Unused pkt_data words SHALL read as zero.
REQ-018 Counters SHALL wrap (pkt_cnt) or saturate (err_cnt) without affecting FSM behaviour.

Reset
REQ-019 While rst=1 at a clk edge the block SHALL enter IDLE, clear the data buffer, status and both counters, and drive rx_ready=0, tx_valid=0, pkt_valid=0, tx_flit=0, pkt_data=0, pkt_words=0, pkt_src=0.
REQ-020 Reset asserted mid-packet SHALL discard the partial packet with no ack and no counter update; rx_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-021 Kind encodings, flit field positions, status codes and the state enum SHALL live in shared package noc_pkg.
REQ-022 The ack flit formatting SHALL be a sub-module noc_ack_builder (combinational); all other logic SHALL be in noc_eject_ni.

Verification
REQ-023 SINGLE to (0,0) from (1,1), data 32'hCAFEBABE -> pkt_valid next cycle, pkt_words=1, pkt_src=8'h11; after pkt_ready, tx_flit kind=11, dst=(1,1), [31:24]=00, [23:16]=01; pkt_cnt=1.
REQ-024 HEAD len=3, then BODY 1, BODY 2, TAIL 3 -> pkt_words=4 with words in order; ack status 00, count 04.
REQ-025 HEAD to (1,0) len=2, then BODY, TAIL -> all flits consumed, no pkt_valid, ack status 01 to source, err_cnt=1.
REQ-026 HEAD len=3 followed by TAIL -> ack status 02, no pkt_valid; a stray BODY in IDLE -> err_cnt increments with no ack.
REQ-027 pkt_ready held low for 10 cycles, then tx_ready held low for 5 cycles -> outputs stable, rx_ready=0 throughout both stalls.
REQ-028 rst pulsed after HEAD+BODY -> outputs at reset values; the next SINGLE is delivered normally with pkt_cnt=1.
